// File: rtl/sddac_mod2_seq_if.sv
// sddac_mod2_seq_if: operand/result bus between the modulator sequencer and the shared MAC unit
interface sddac_mod2_seq_if;
   logic        [8:0]  op;
   logic signed [17:0] a;
   logic signed [17:0] b;
   logic signed [47:0] c;
   logic signed [47:0] p;
   modport master(output op, a, b, c, input p);
   modport slave(input op, a, b, c, output p);
endinterface

// File: rtl/sddac_mod2_seq.sv
// sddac_mod2_seq: second-order sigma-delta modulator sequencing two integrator updates per step on a shared MAC
module sddac_mod2_seq #(
   parameter int                 STEP_CYCLES = 8,
   parameter logic signed [17:0] K1          = 18'sd65536,
   parameter logic signed [17:0] K2          = 18'sd65536,
   parameter logic signed [47:0] FB1         = 48'sd8589934592,
   parameter logic signed [47:0] FB2         = 48'sd8589934592,
   parameter int                 S1_SHIFT    = 17,
   parameter logic signed [47:0] INT_LIM     = 48'sd1099511627776
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic signed [17:0] sample_in,
   input  logic               sample_valid,
   output logic               dout,
   output logic               dout_valid,
   output logic               ovf,
   sddac_mod2_seq_if.master   mac
);
   localparam int KW = $clog2(STEP_CYCLES);
   typedef enum logic {IDLE, RUN} state_t;
   state_t             state;
   logic [KW-1:0]      k;
   logic signed [17:0] pend, a2, a2_n;
   logic signed [47:0] s1, s2, pc, sh;
   logic               issue0, issue4, wrap;
   // The k=0 issue takes the pending register directly so the sample is used in the step it was captured for
   always_comb begin
      issue0 = state == RUN && k == KW'(0);
      issue4 = state == RUN && k == KW'(4);
      wrap   = k == KW'(STEP_CYCLES - 1);
      pc     = mac.p > INT_LIM ? INT_LIM : mac.p < -INT_LIM ? -INT_LIM : mac.p;
      sh     = pc >>> S1_SHIFT;
      a2_n   = sh > 48'sd131071 ? 18'h1FFFF : sh < -48'sd131072 ? 18'h20000 : sh[17:0];
      mac.op = issue0 || issue4 ? 9'h00D : 9'h000;
      mac.a  = issue0 ? pend : issue4 ? a2 : 18'sd0;
      mac.b  = issue0 ? K1 : issue4 ? K2 : 18'sd0;
      mac.c  = issue0 ? (dout ? s1 - FB1 : s1 + FB1) : issue4 ? (dout ? s2 - FB2 : s2 + FB2) : 48'sd0;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         k          <= '0;
         pend       <= '0;
         a2         <= '0;
         s1         <= '0;
         s2         <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         if (sample_valid) pend <= sample_in;
         dout_valid <= 1'b0;
         ovf        <= 1'b0;
         if (state == IDLE) begin
            k <= '0;
            if (en) state <= RUN;
         end else begin
            k <= wrap ? '0 : k + 1'b1;
            if (wrap && !en) state <= IDLE;
            if (k == KW'(3)) begin
               s1  <= pc;
               a2  <= a2_n;
               ovf <= pc != mac.p;
            end
            if (k == KW'(7)) begin
               s2         <= pc;
               dout       <= !pc[47];
               dout_valid <= 1'b1;
               ovf        <= pc != mac.p;
            end
         end
      end
endmodule
